// File: rtl/sme_param.sv
// sme_param: parametrised string-match engine.
//   Loads a string, then one or more patterns, and searches the stored string
//   for each pattern, testing one start position per cycle. Pattern syntax:
//   '^' = word start, '$' = word end, '.' = any single character.
// Parameters: DATA_W (char width), STR_MAX (max string length),
//   PAT_MAX (max pattern length including anchors).
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   chardata    in   input character
//   isstring    in   chardata is a string character
//   ispattern   in   chardata is a pattern character
//   valid       out  one-cycle pulse, match/match_index valid
//   match       out  pattern found
//   match_index out  start index of the first matching core character
//   busy        out  high while scanning or presenting a result
// Build option: define SME_CASE_FOLD_EN for case-insensitive ASCII letters.
module sme_param #(
  parameter int DATA_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          chardata,
  input  logic                       isstring,
  input  logic                       ispattern,
  output logic                       valid,
  output logic                       match,
  output logic [$clog2(STR_MAX)-1:0] match_index,
  output logic                       busy
);
  localparam int IDX_W = $clog2(STR_MAX);
  localparam int AW    = IDX_W + 1;
  localparam int PW    = $clog2(PAT_MAX + 1);
  // Scan arithmetic is one bit wider than either length so sums never wrap.
  localparam int SW    = ((AW > PW) ? AW : PW) + 1;

  localparam logic [DATA_W-1:0] SP     = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] DOT    = DATA_W'(8'h2E);
  localparam logic [DATA_W-1:0] CARET  = DATA_W'(8'h5E);
  localparam logic [DATA_W-1:0] DOLLAR = DATA_W'(8'h24);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  str_q [STR_MAX];
  logic [DATA_W-1:0]  pat_q [PAT_MAX];
  logic [AW-1:0]      str_len_q;
  logic [PW-1:0]      pat_len_q;
  logic               prev_str_q, prev_pat_q;
  logic [SW-1:0]      i_q, len_q;
  logic               anc_s_q, anc_e_q;
  logic               valid_q, match_q;
  logic [IDX_W-1:0]   idx_q;

  logic               core_ok, left_ok, right_ok, hit, no_fit, last_pos;
  logic               dec_anc_s, dec_anc_e;
  logic [SW-1:0]      dec_len;
  logic [PW-1:0]      pat_last;
  logic [DATA_W-1:0]  pc, sc;

  assign valid       = valid_q;
  assign match       = match_q;
  assign match_index = idx_q;
  assign busy        = (state_q != IDLE);

  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] c);
`ifdef SME_CASE_FOLD_EN
    if (c >= DATA_W'(8'h41) && c <= DATA_W'(8'h5A)) return c + DATA_W'(8'h20);
`endif
    return c;
  endfunction

  // Positions at or beyond the stored length read as a space, which also
  // covers the wrapped i-1 at i==0.
  function automatic logic [DATA_W-1:0] rd_str(input logic [SW-1:0] pos);
    if (pos < SW'(str_len_q)) return str_q[pos[IDX_W-1:0]];
    return SP;
  endfunction

  always_comb begin
    core_ok = 1'b1;
    pc      = '0;
    sc      = '0;
    for (int unsigned k = 0; k < PAT_MAX; k++) begin
      if (k < 32'(len_q)) begin
        pc = pat_q[PW'(k + 32'(anc_s_q))];
        sc = rd_str(i_q + SW'(k));
        if (pc != DOT && fold(sc) != fold(pc)) core_ok = 1'b0;
      end
    end
    left_ok  = !anc_s_q || (i_q == '0) || (rd_str(i_q - SW'(1)) == SP);
    right_ok = !anc_e_q || (i_q + len_q == SW'(str_len_q)) ||
               (rd_str(i_q + len_q) == SP);
    hit      = core_ok && left_ok && right_ok;
    no_fit   = (len_q == '0) || (len_q > SW'(str_len_q));
    last_pos = (i_q + len_q >= SW'(str_len_q));

    pat_last  = pat_len_q - PW'(1);
    dec_anc_s = (pat_q[0] == CARET);
    dec_anc_e = (pat_len_q != '0) && (pat_q[pat_last] == DOLLAR);
    dec_len   = SW'(pat_len_q) - SW'(dec_anc_s) - SW'(dec_anc_e);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      str_len_q  <= '0;
      pat_len_q  <= '0;
      prev_str_q <= 1'b0;
      prev_pat_q <= 1'b0;
      i_q        <= '0;
      len_q      <= '0;
      anc_s_q    <= 1'b0;
      anc_e_q    <= 1'b0;
      for (int unsigned n = 0; n < STR_MAX; n++) str_q[n] <= '0;
      for (int unsigned n = 0; n < PAT_MAX; n++) pat_q[n] <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          prev_str_q <= isstring;
          prev_pat_q <= ispattern && !isstring;
          if (isstring) begin
            if (!prev_str_q) begin
              str_q[0]  <= chardata;
              str_len_q <= AW'(1);
            end else if (str_len_q < AW'(STR_MAX)) begin
              str_q[str_len_q[IDX_W-1:0]] <= chardata;
              str_len_q <= str_len_q + AW'(1);
            end
          end else if (ispattern) begin
            if (!prev_pat_q) begin
              pat_q[0]  <= chardata;
              pat_len_q <= PW'(1);
            end else if (pat_len_q < PW'(PAT_MAX)) begin
              pat_q[pat_len_q] <= chardata;
              pat_len_q <= pat_len_q + PW'(1);
            end
          end else if (prev_pat_q) begin
            state_q <= SCAN;
            i_q     <= '0;
            anc_s_q <= dec_anc_s;
            anc_e_q <= dec_anc_e;
            len_q   <= dec_len;
          end
        end
        SCAN: begin
          if (no_fit || hit || last_pos) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            match_q <= !no_fit && hit;
            idx_q   <= (!no_fit && hit) ? i_q[IDX_W-1:0] : '0;
          end else begin
            i_q <= i_q + SW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_param.sv
module tb_sme_param;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       chardata = '0;
  logic             isstring = 1'b0;
  logic             ispattern = 1'b0;
  logic             valid, match, busy;
  logic [IDX_W-1:0] match_index;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sme_param #(.DATA_W(8), .STR_MAX(32), .PAT_MAX(10)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .busy(busy)
  );

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); chardata = s[i]; isstring = 1'b1; ispattern = 1'b0;
    end
    @(negedge clk); isstring = 1'b0; chardata = '0;
  endtask

  // Drives a pattern run plus the idle cycle that starts the scan, then
  // waits (bounded) for valid; cyc counts clock edges from the idle cycle.
  task automatic run_pat(input string p, output logic m, output logic [IDX_W-1:0] idx,
                         output int cyc, output bit seen, output bit busy_ok,
                         output logic av, output logic ab);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk); chardata = p[i]; ispattern = 1'b1;
    end
    @(negedge clk); ispattern = 1'b0; chardata = '0;
    seen = 1'b0; cyc = 0; busy_ok = 1'b1; m = 1'bx; idx = 'x;
    while (!seen && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (valid) begin
        seen = 1'b1; m = match; idx = match_index;
        if (!busy) busy_ok = 1'b0;
      end else if (!busy) busy_ok = 1'b0;
    end
    @(negedge clk); av = valid; ab = busy;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", valid); end
    vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL rst_match: got %b expected 0", match); end
    vectors++; if (match_index !== '0) begin miscompares++; $display("FAIL rst_index: got %0d expected 0", match_index); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic m; logic [IDX_W-1:0] idx; int cyc; bit seen, bok; logic av, ab;
    send_str("hello world");
    run_pat("wor", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL t1_valid: got %b expected 1", seen); end
    vectors++; if (cyc != 8) begin miscompares++; $display("FAIL t1_latency: got %0d expected 8", cyc); end
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL t1_match: got %b expected 1", m); end
    vectors++; if (idx !== 5'd6) begin miscompares++; $display("FAIL t1_index: got %0d expected 6", idx); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL t1_busy_scan: got %b expected 1", bok); end
    vectors++; if (av !== 1'b0) begin miscompares++; $display("FAIL t1_valid_pulse: got %b expected 0", av); end
    vectors++; if (ab !== 1'b0) begin miscompares++; $display("FAIL t1_busy_after: got %b expected 0", ab); end
  endtask

  task automatic test_anchors;
    logic m; logic [IDX_W-1:0] idx; int cyc; bit seen, bok; logic av, ab;
    run_pat("^w.rld$", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL t2a_match: got %b expected 1", m); end
    vectors++; if (idx !== 5'd6) begin miscompares++; $display("FAIL t2a_index: got %0d expected 6", idx); end
    vectors++; if (cyc != 8) begin miscompares++; $display("FAIL t2a_latency: got %0d expected 8", cyc); end
    run_pat("^orl", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL t2b_match: got %b expected 0", m); end
    vectors++; if (idx !== 5'd0) begin miscompares++; $display("FAIL t2b_index: got %0d expected 0", idx); end
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL t2b_latency: got %0d expected 10", cyc); end
    run_pat("ld$", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL t3a_match: got %b expected 1", m); end
    vectors++; if (idx !== 5'd9) begin miscompares++; $display("FAIL t3a_index: got %0d expected 9", idx); end
    vectors++; if (cyc != 11) begin miscompares++; $display("FAIL t3a_latency: got %0d expected 11", cyc); end
    run_pat("he.l", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL t3b_match: got %b expected 1", m); end
    vectors++; if (idx !== 5'd0) begin miscompares++; $display("FAIL t3b_index: got %0d expected 0", idx); end
    vectors++; if (cyc != 2) begin miscompares++; $display("FAIL t3b_latency: got %0d expected 2", cyc); end
  endtask

  task automatic test_case_fold;
    logic m; logic [IDX_W-1:0] idx; int cyc; bit seen, bok; logic av, ab;
    run_pat("WOR", m, idx, cyc, seen, bok, av, ab);
`ifdef SME_CASE_FOLD_EN
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL t6_match: got %b expected 1", m); end
    vectors++; if (idx !== 5'd6) begin miscompares++; $display("FAIL t6_index: got %0d expected 6", idx); end
`else
    vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL t6_match: got %b expected 0", m); end
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL t6_latency: got %0d expected 10", cyc); end
`endif
  endtask

  task automatic test_saturation;
    logic m; logic [IDX_W-1:0] idx; int cyc; bit seen, bok; logic av, ab;
    send_str("abcdefghijklmnopqrstuvwxyz0123456789!@#%");
    run_pat("@#%", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL t4a_match: got %b expected 0", m); end
    vectors++; if (cyc != 31) begin miscompares++; $display("FAIL t4a_latency: got %0d expected 31", cyc); end
    run_pat("345", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL t4b_match: got %b expected 1", m); end
    vectors++; if (idx !== 5'd29) begin miscompares++; $display("FAIL t4b_index: got %0d expected 29", idx); end
  endtask

  task automatic test_reset_mid_scan;
    logic m; logic [IDX_W-1:0] idx; int cyc; bit seen, bok; logic av, ab;
    int pulses;
    send_str("hello world");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chardata = (i == 0) ? 8'h72 : (i == 1) ? 8'h6C : 8'h64; ispattern = 1'b1;
    end
    @(negedge clk); ispattern = 1'b0; chardata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t5_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    vectors++; if ({valid, match, match_index, busy} !== '0) begin miscompares++;
      $display("FAIL t5_outputs: got v=%b m=%b i=%0d b=%b expected all 0", valid, match, match_index, busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (valid) pulses++; end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL t5_no_pulse: got %0d expected 0", pulses); end
    send_str("hello world");
    run_pat("wor", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b1 || idx !== 5'd6) begin miscompares++;
      $display("FAIL t5_reload: got m=%b i=%0d expected m=1 i=6", m, idx); end
  endtask

  task automatic test_priority_and_fit;
    logic m; logic [IDX_W-1:0] idx; int cyc; bit seen, bok; logic av, ab;
    @(negedge clk); chardata = 8'h61; isstring = 1'b1;
    @(negedge clk); chardata = 8'h62;
    @(negedge clk); chardata = 8'h78; ispattern = 1'b1;
    @(negedge clk); isstring = 1'b0; ispattern = 1'b0; chardata = '0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL prio_no_scan: got %b expected 0", busy); end
    run_pat("bx", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b1 || idx !== 5'd1) begin miscompares++;
      $display("FAIL prio_match: got m=%b i=%0d expected m=1 i=1", m, idx); end
    vectors++; if (cyc != 3) begin miscompares++; $display("FAIL prio_latency: got %0d expected 3", cyc); end
    run_pat("abxy", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b0 || cyc != 2) begin miscompares++;
      $display("FAIL too_long: got m=%b cyc=%0d expected m=0 cyc=2", m, cyc); end
    run_pat("^", m, idx, cyc, seen, bok, av, ab);
    vectors++; if (m !== 1'b0 || cyc != 2) begin miscompares++;
      $display("FAIL empty_core: got m=%b cyc=%0d expected m=0 cyc=2", m, cyc); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_anchors;
    test_case_fold;
    test_saturation;
    test_reset_mid_scan;
    test_priority_and_fit;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
